fb_scan_out: RTL

Display scan-out stage that reads the 320×240, 12-bit frame buffer SRAM and drives a 640×480 @ 60 Hz VGA port. It owns the VGA timing counters, generates a read address for each displayed pixel (2× horizontal and vertical pixel doubling), absorbs the SRAM's one-clock read latency through a two-stage pixel pipeline, and emits RGB444 plus sync signals. It sits directly downstream of the frame-buffer SRAM read port.

---
 rtl/fb_scan_out_pkg.sv | 54 +++++
 rtl/fb_scan_out_vga_timing.sv | 69 ++++++
 rtl/fb_scan_out.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fb_scan_out_pkg.sv
// Shared display definitions: VGA 640x480@60 timing, frame-buffer geometry,
// SRAM port widths and the address helper used by scan-out and writers.
package fb_scan_out_pkg;

    // Horizontal timing in pixel clocks
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Frame buffer: each stored pixel covers a 2x2 block on screen
    localparam int FB_WIDTH   = 320;
    localparam int FB_HEIGHT  = 240;
    localparam int DATA_WIDTH = 12;
    localparam int ADDR_WIDTH = 17;

    // Raster counters must hold H_TOTAL-1 and V_TOTAL-1
    localparam int CNT_W  = 10;
    localparam int FB_X_W = $clog2(FB_WIDTH);
    localparam int FB_Y_W = $clog2(FB_HEIGHT);

    typedef logic [CNT_W-1:0]      cnt_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] pixel_t;
    typedef logic [FB_X_W-1:0]     fb_x_t;
    typedef logic [FB_Y_W-1:0]     fb_y_t;

    // Per-pixel control bits that travel alongside the colour data
    typedef struct packed {
        logic video_on;
        logic hsync_n;
        logic vsync_n;
        logic first;
    } scan_ctrl_t;

    localparam scan_ctrl_t SCAN_CTRL_IDLE = '{video_on: 1'b0, hsync_n: 1'b1,
                                              vsync_n: 1'b1, first: 1'b0};

    // Linear frame-buffer address y*320 + x, built from shifts (256 + 64 = 320)
    function automatic addr_t fb_addr(input fb_y_t y, input fb_x_t x);
        addr_t y_ext;
        y_ext = addr_t'(y);
        return (y_ext << 8) + (y_ext << 6) + addr_t'(x);
    endfunction

endpackage

// File: rtl/fb_scan_out_vga_timing.sv
// VGA raster generator: h/v counters stepped by the pixel strobe, plus the
// stage-0 decode (video_on, raw syncs, first-pixel flag, frame-buffer x/y).
module fb_scan_out_vga_timing
    import fb_scan_out_pkg::*;
#(
    parameter int V_ACTIVE_LINES = V_ACTIVE,
    parameter int V_FP_LINES     = V_FP,
    parameter int V_SYNC_LINES   = V_SYNC,
    parameter int V_BP_LINES     = V_BP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_tick_i,
    output logic              video_on_o,
    output logic              hsync_n_o,
    output logic              vsync_n_o,
    output logic              first_pixel_o,
    output logic [FB_X_W-1:0] pixel_x_o,
    output logic [FB_Y_W-1:0] pixel_y_o
);

    localparam int V_TOTAL_LINES = V_ACTIVE_LINES + V_FP_LINES + V_SYNC_LINES + V_BP_LINES;

    localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
    localparam cnt_t H_VIS_END = cnt_t'(H_ACTIVE);
    localparam cnt_t HS_START  = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END    = cnt_t'(H_ACTIVE + H_FP + H_SYNC);

    localparam cnt_t V_LAST    = cnt_t'(V_TOTAL_LINES - 1);
    localparam cnt_t V_VIS_END = cnt_t'(V_ACTIVE_LINES);
    localparam cnt_t VS_START  = cnt_t'(V_ACTIVE_LINES + V_FP_LINES);
    localparam cnt_t VS_END    = cnt_t'(V_ACTIVE_LINES + V_FP_LINES + V_SYNC_LINES);

    cnt_t h_cnt_q, h_cnt_d;
    cnt_t v_cnt_q, v_cnt_d;

    // Next raster position: h wraps at end of line and carries into v
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        h_cnt_d = h_cnt_q + cnt_t'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
        end
    end

    // Raster counters advance only on the pixel strobe; otherwise frozen
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else if (pixel_tick_i) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign video_on_o    = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
    assign hsync_n_o     = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    assign vsync_n_o     = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    assign first_pixel_o = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Dropping the LSB doubles each frame-buffer pixel in both directions
    assign pixel_x_o = h_cnt_q[FB_X_W:1];
    assign pixel_y_o = v_cnt_q[FB_Y_W:1];

endmodule

// File: rtl/fb_scan_out.sv
// Frame-buffer scan-out: turns the raster position into SRAM read addresses
// and carries colour and syncs through a two-stage pipeline so they stay
// aligned across the SRAM's one-clock read latency.
module fb_scan_out
    import fb_scan_out_pkg::*;
#(
    parameter int V_ACTIVE_LINES = V_ACTIVE,
    parameter int V_FP_LINES     = V_FP,
    parameter int V_SYNC_LINES   = V_SYNC,
    parameter int V_BP_LINES     = V_BP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pixel_tick,
    output logic                  sram_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_data,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic                  frame_start
);

    logic  video_on;
    logic  hsync_n;
    logic  vsync_n;
    logic  first_pixel;
    fb_x_t pixel_x;
    fb_y_t pixel_y;

    fb_scan_out_vga_timing #(
        .V_ACTIVE_LINES (V_ACTIVE_LINES),
        .V_FP_LINES     (V_FP_LINES),
        .V_SYNC_LINES   (V_SYNC_LINES),
        .V_BP_LINES     (V_BP_LINES)
    ) u_timing (
        .clk           (clk),
        .reset         (reset),
        .pixel_tick_i  (pixel_tick),
        .video_on_o    (video_on),
        .hsync_n_o     (hsync_n),
        .vsync_n_o     (vsync_n),
        .first_pixel_o (first_pixel),
        .pixel_x_o     (pixel_x),
        .pixel_y_o     (pixel_y)
    );

    // Stage 1: address / enable towards the SRAM plus matching control bits
    scan_ctrl_t s1_ctrl_q, s1_ctrl_d;
    addr_t      sram_addr_q, sram_addr_d;
    logic       sram_en_q, sram_en_d;

    // Stage 2: pin registers
    pixel_t     rgb_q, rgb_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       frame_start_q, frame_start_d;

    // Stage-1 next state: capture the decode; address holds through blanking
    always_comb begin
        s1_ctrl_d   = '{video_on: video_on, hsync_n: hsync_n,
                        vsync_n: vsync_n, first: first_pixel};
        sram_en_d   = video_on;
        sram_addr_d = sram_addr_q;
        if (video_on) begin
            sram_addr_d = fb_addr(pixel_y, pixel_x);
        end
    end

    // Stage-1 registers load on each pixel strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_ctrl_q   <= SCAN_CTRL_IDLE;
            sram_en_q   <= 1'b0;
            sram_addr_q <= '0;
        end else if (pixel_tick) begin
            s1_ctrl_q   <= s1_ctrl_d;
            sram_en_q   <= sram_en_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    // Stage-2 next state: blank colour outside the active area, pass syncs on.
    // The SRAM answered at least one clock before this strobe because strobes
    // are never closer than two clocks apart.
    always_comb begin
        rgb_d         = s1_ctrl_q.video_on ? sram_data : '0;
        hsync_d       = s1_ctrl_q.hsync_n;
        vsync_d       = s1_ctrl_q.vsync_n;
        frame_start_d = pixel_tick && s1_ctrl_q.first;
    end

    // Stage-2 registers; frame_start is re-evaluated every clock so it is a single-clock pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
            if (pixel_tick) begin
                rgb_q   <= rgb_d;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
            end
        end
    end

    assign sram_en     = sram_en_q;
    assign sram_addr   = sram_addr_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign frame_start = frame_start_q;

endmodule
